// File: rtl/issuemult_sched.sv
// Multiplier issue scheduler: collapsing reservation queue with CDB wakeup,
// oldest-ready-first issue and a fixed-latency completion tracker.
module issuemult_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [15:0] disp_rsdata,
  input  logic [15:0] disp_rtdata,
  input  logic        disp_rsvalid,
  input  logic        disp_rtvalid,
  input  logic [5:0]  disp_rstag,
  input  logic [5:0]  disp_rttag,
  input  logic [5:0]  disp_rdtag,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        flush,
  output logic [15:0] issuemult_rsdata,
  output logic [15:0] issuemult_rtdata,
  output logic [5:0]  issuemult_rdtag,
  output logic        issue_valid,
  output logic        done_valid,
  output logic [5:0]  done_tag
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        valid;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        rs_rdy;
    logic        rt_rdy;
    logic [5:0]  rs_tag;
    logic [5:0]  rt_tag;
    logic [5:0]  rd_tag;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          woken [DEPTH];
  entry_t          disp_ent;
  logic [DEPTH-1:0] rdy;
  logic [IdxW-1:0] sel;
  logic            any_rdy;
  logic            issue_fire;
  logic            disp_fire;
  logic [CntW-1:0] count;
  logic [CntW-1:0] wr_idx;

  logic            iss_valid_q;
  logic [15:0]     iss_rs_q;
  logic [15:0]     iss_rt_q;
  logic [5:0]      iss_rd_q;
  logic [LATENCY-1:0] pipe_v_q;
  logic [5:0]      pipe_tag_q [LATENCY];

  logic            unused_cdb_hi;
  assign unused_cdb_hi = ^cdb_data[31:16];

  // Capture a broadcast value into any operand still waiting on that tag.
  function automatic entry_t wake(input entry_t e, input logic cv, input logic [5:0] ct,
                                  input logic [15:0] cd);
    entry_t r;
    r = e;
    if (cv && !r.rs_rdy && (r.rs_tag == ct)) begin
      r.rs_data = cd;
      r.rs_rdy  = 1'b1;
    end
    if (cv && !r.rt_rdy && (r.rt_tag == ct)) begin
      r.rt_data = cd;
      r.rt_rdy  = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    rdy     = '0;
    sel     = '0;
    count   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ent_q[i].valid & ent_q[i].rs_rdy & ent_q[i].rt_rdy;
      if (rdy[i]) sel = IdxW'(i);
      count = count + CntW'(ent_q[i].valid);
    end
    any_rdy    = |rdy;
    issue_fire = any_rdy & ~flush;
    disp_ready = (count < CntW'(DEPTH)) | issue_fire;
    disp_fire  = disp_valid & disp_ready & ~flush;
    wr_idx     = count - CntW'(issue_fire);
  end

  always_comb begin
    disp_ent = '{valid:   1'b1,
                 rs_data: disp_rsdata,
                 rt_data: disp_rtdata,
                 rs_rdy:  disp_rsvalid,
                 rt_rdy:  disp_rtvalid,
                 rs_tag:  disp_rstag,
                 rt_tag:  disp_rttag,
                 rd_tag:  disp_rdtag};
    disp_ent = wake(disp_ent, cdb_valid, cdb_tag, cdb_data[15:0]);
    for (int j = 0; j < int'(DEPTH); j++) begin
      woken[j] = wake(ent_q[j], cdb_valid, cdb_tag, cdb_data[15:0]);
      ent_d[j] = woken[j];
    end
    // Entries above the issued slot slide down by one.
    for (int j = 0; j < int'(DEPTH) - 1; j++) begin
      if (issue_fire && (IdxW'(j) >= sel)) ent_d[j] = woken[j+1];
    end
    if (issue_fire) ent_d[DEPTH-1] = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (disp_fire && (wr_idx == CntW'(j))) ent_d[j] = disp_ent;
    end
    if (flush) begin
      for (int j = 0; j < int'(DEPTH); j++) ent_d[j].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      iss_valid_q <= 1'b0;
      iss_rs_q    <= '0;
      iss_rt_q    <= '0;
      iss_rd_q    <= '0;
      pipe_v_q    <= '0;
      for (int k = 0; k < int'(LATENCY); k++) pipe_tag_q[k] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
      iss_valid_q <= issue_fire;
      if (issue_fire) begin
        iss_rs_q <= ent_q[sel].rs_data;
        iss_rt_q <= ent_q[sel].rt_data;
        iss_rd_q <= ent_q[sel].rd_tag;
      end
      // Fed from the registered issue so done lands LATENCY cycles after issue_valid.
      pipe_v_q[0]   <= iss_valid_q & ~flush;
      pipe_tag_q[0] <= iss_rd_q;
      for (int k = 1; k < int'(LATENCY); k++) begin
        pipe_v_q[k]   <= pipe_v_q[k-1] & ~flush;
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
    end
  end

  assign issue_valid      = iss_valid_q;
  assign issuemult_rsdata = iss_rs_q;
  assign issuemult_rtdata = iss_rt_q;
  assign issuemult_rdtag  = iss_rd_q;
  assign done_valid       = pipe_v_q[LATENCY-1];
  assign done_tag         = pipe_tag_q[LATENCY-1];

endmodule

// File: doc/issuemult_sched.md
ISSUEMULT_SCHED -- requirements
Module: issuemult_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of reservation entries.
REQ-002 SHALL have parameter LATENCY, default 3, cycles from issue to multiplier result valid.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port disp_valid  input  1  dispatch request.
REQ-006 SHALL have port disp_ready  output  1  queue can accept a dispatch this cycle.
REQ-007 SHALL have ports disp_rsdata/disp_rtdata  input  16 each  operand values.
REQ-008 SHALL have ports disp_rsvalid/disp_rtvalid  input  1 each  operand already available.
REQ-009 SHALL have ports disp_rstag/disp_rttag  input  6 each  producer tags for pending operands.
REQ-010 SHALL have port disp_rdtag  input  6  destination tag.
REQ-011 SHALL have ports cdb_valid  input  1, cdb_tag  input  6, cdb_data  input  32  broadcast; low 16 bits are the operand value.
REQ-012 SHALL have port flush  input  1  synchronous squash of all queued and in-flight work.
REQ-013 SHALL have ports issuemult_rsdata/issuemult_rtdata  output  16 each, issuemult_rdtag  output  6, issue_valid  output  1  registered multiplier issue.
REQ-014 SHALL have ports done_valid  output  1, done_tag  output  6  completion marker aligned with multiplier result.

Function
REQ-015 SHALL hold a collapsing queue; slot 0 oldest; per entry: valid, rs/rt value, rs/rt ready, rs/rt tag, rdtag.
REQ-016 SHALL assert disp_ready when occupied count < DEPTH, or count == DEPTH and an issue occurs this cycle.
REQ-017 SHALL write a dispatch (disp_valid & disp_ready) into the first free slot after same-cycle collapse.
REQ-018 SHALL, when cdb_valid and cdb_tag matches a not-ready operand tag, capture cdb_data[15:0] and set that operand ready.
REQ-019 SHALL apply REQ-018 also to the entry being dispatched in the same cycle (operand with valid=0 and matching tag captured directly).
REQ-020 SHALL treat an entry as ready when both operands ready at start of cycle; CDB wakeup makes it eligible the following cycle.
REQ-021 SHALL select the lowest-index ready entry, at most one issue per cycle.
REQ-022 SHALL register the selected entry's rs/rt/rdtag onto issuemult_* with issue_valid=1 for exactly one cycle; issue_valid=0 otherwise, data outputs hold last value.
REQ-023 SHALL remove the issued entry and shift all higher entries down by one in the same edge.
REQ-024 SHALL track in-flight issues in a LATENCY-deep valid+tag shift register; done_valid/done_tag SHALL assert exactly LATENCY cycles after issue_valid.
REQ-025 SHALL accept issues every cycle (fully pipelined multiplier; no back-pressure on done).
REQ-026 SHALL, on flush, clear all queue valid bits and in-flight valid bits at the next edge; issue_valid and done_valid SHALL be 0 the cycle after flush; dispatch in the flush cycle is dropped.
REQ-027 SHALL give flush priority over dispatch, issue and wakeup in the same cycle.
REQ-028 SHALL ignore disp_valid when disp_ready=0 (no state change).

Reset
REQ-029 SHALL, while reset low, asynchronously clear all entry valid bits, in-flight valid bits, issue_valid, done_valid, and drive issuemult_rsdata/rtdata/rdtag and done_tag to 0.
REQ-030 SHALL assert disp_ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL discard in-flight work when reset asserts mid-operation; no done_valid after release for pre-reset issues.

Verification
REQ-032 Ready dispatch rs=0x0003 rt=0x0005 rd=0x0A -> issue_valid next cycle with same values, done_valid/done_tag=0x0A 3 cycles later.
REQ-033 Dispatch rs pending tag 0x11, then cdb_valid tag 0x11 data 0x0000_0007 -> entry issues cycle after CDB with rsdata=0x0007.
REQ-034 Dispatch with rt pending tag 0x22 concurrent with cdb tag 0x22 data 0x0009 -> captured, issues next cycle, rtdata=0x0009.
REQ-035 Fill 4 non-ready entries -> disp_ready=0; wake slot 2 -> issues, slots 3 shift to 2, disp_ready=1; fifth dispatch lands in slot 3.
REQ-036 Four back-to-back ready dispatches -> four consecutive issues, four consecutive done pulses in order.
REQ-037 Flush with 2 queued and 2 in flight -> no issue_valid/done_valid afterward; reset low mid-pipeline -> all outputs 0 immediately.
